// File: rtl/ef9345_bus_sequencer_pkg.sv
// Shared state encoding and default bus timing for the EF9345 host-side bus sequencer.
package ef9345_bus_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_AHOLD   = 3'd2,
    ST_DATA    = 3'd3,
    ST_RECOVER = 3'd4
  } state_e;

  localparam int T_AS_DEF  = 2;
  localparam int T_DS_DEF  = 3;
  localparam int T_REC_DEF = 1;
  localparam int CNT_W     = 4;

endpackage

// File: rtl/ef9345_bus_sequencer.sv
// Sequences one host read/write into EF9345 multiplexed-bus strobes:
// address phase, address hold, data phase, then chip-select recovery.
module ef9345_bus_sequencer
  import ef9345_bus_sequencer_pkg::*;
#(
  parameter int T_AS  = T_AS_DEF,
  parameter int T_DS  = T_DS_DEF,
  parameter int T_REC = T_REC_DEF
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       req,
  input  logic       req_rd,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       ready,
  output logic       done,
  output logic [7:0] rdata,
  output logic       as,
  output logic       ds,
  output logic       rw,
  output logic       cs_,
  output logic [7:0] bus_out,
  output logic       bus_out_en,
  input  logic [7:0] bus_in
);

  // Counter holds "cycles remaining minus one" so a phase ends when it reads zero.
  localparam logic [CNT_W-1:0] T_AS_M1  = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0] T_DS_M1  = CNT_W'(T_DS - 1);
  localparam logic [CNT_W-1:0] T_REC_M1 = CNT_W'(T_REC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_q, rd_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ready      = 1'b0;
    done       = 1'b0;
    as         = 1'b0;
    ds         = 1'b0;
    rw         = 1'b1;
    cs_        = 1'b1;
    bus_out    = 8'h00;
    bus_out_en = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (req) begin
          state_d = ST_ADDR;
          cnt_d   = T_AS_M1;
          rd_d    = req_rd;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      ST_ADDR: begin
        cs_        = 1'b0;
        as         = 1'b1;
        rw         = rd_q;
        bus_out    = addr_q;
        bus_out_en = 1'b1;
        if (cnt_q == '0) state_d = ST_AHOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_AHOLD: begin
        // Address stays on the bus one cycle past the falling edge of as.
        cs_        = 1'b0;
        rw         = rd_q;
        bus_out    = addr_q;
        bus_out_en = 1'b1;
        state_d    = ST_DATA;
        cnt_d      = T_DS_M1;
      end
      ST_DATA: begin
        cs_ = 1'b0;
        ds  = 1'b1;
        rw  = rd_q;
        if (!rd_q) begin
          bus_out    = wdata_q;
          bus_out_en = 1'b1;
        end
        if (cnt_q == '0) begin
          state_d = ST_RECOVER;
          cnt_d   = T_REC_M1;
          if (rd_q) rdata_d = bus_in;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RECOVER: begin
        done = (cnt_q == T_REC_M1);
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and wins over req.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_ef9345_bus_sequencer.sv
// Self-checking bench: directed and randomized accesses against a cycle-position
// reference model, plus a minimum-timing instance.
module tb_ef9345_bus_sequencer;

  localparam int TAS  = 2;
  localparam int TDS  = 3;
  localparam int TREC = 1;
  localparam int LEN  = TAS + 1 + TDS + TREC;

  localparam int PH_ADDR = 1, PH_AHOLD = 2, PH_DATA = 3, PH_REC = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       a_req, a_rd, a_ready, a_done, a_as, a_ds, a_rw, a_cs_n, a_en;
  logic [7:0] a_addr, a_wdata, a_rdata, a_bus_out, a_bus_in;

  logic       b_req, b_rd, b_ready, b_done, b_as, b_ds, b_rw, b_cs_n, b_en;
  logic [7:0] b_addr, b_wdata, b_rdata, b_bus_out, b_bus_in;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_rdata;

  ef9345_bus_sequencer dut_a (
    .clk_in(clk), .reset(reset), .req(a_req), .req_rd(a_rd), .req_addr(a_addr),
    .req_wdata(a_wdata), .ready(a_ready), .done(a_done), .rdata(a_rdata), .as(a_as),
    .ds(a_ds), .rw(a_rw), .cs_(a_cs_n), .bus_out(a_bus_out), .bus_out_en(a_en),
    .bus_in(a_bus_in)
  );

  ef9345_bus_sequencer #(.T_AS(1), .T_DS(1), .T_REC(1)) dut_b (
    .clk_in(clk), .reset(reset), .req(b_req), .req_rd(b_rd), .req_addr(b_addr),
    .req_wdata(b_wdata), .ready(b_ready), .done(b_done), .rdata(b_rdata), .as(b_as),
    .ds(b_ds), .rw(b_rw), .cs_(b_cs_n), .bus_out(b_bus_out), .bus_out_en(b_en),
    .bus_in(b_bus_in)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Position k (1-based from the first ADDR cycle) -> bus phase.
  function automatic int phase_of(int k, int tas, int tds);
    if (k <= tas)           return PH_ADDR;
    if (k == tas + 1)       return PH_AHOLD;
    if (k <= tas + 1 + tds) return PH_DATA;
    return PH_REC;
  endfunction

  // Called in an IDLE cycle; leaves the bench in the IDLE cycle after the access.
  task automatic run_access(input bit rd, input logic [7:0] addr, input logic [7:0] wdata,
                            input logic [7:0] rdv, input bit hold, input bit poke);
    int ph;
    int dones = 0;
    check("idle_ready", a_ready, 1);
    a_req = 1'b1; a_rd = rd; a_addr = addr; a_wdata = wdata;
    for (int k = 1; k <= LEN; k++) begin
      step;
      if (!hold) a_req = (poke && k == TAS + 2);
      a_rd = 1'($urandom); a_addr = 8'($urandom); a_wdata = 8'($urandom);
      ph = phase_of(k, TAS, TDS);
      a_bus_in = (rd && k == TAS + 1 + TDS) ? rdv : 8'($urandom);
      check("as",    a_as,   ph == PH_ADDR);
      check("ds",    a_ds,   ph == PH_DATA);
      check("as_ds_excl", a_as & a_ds, 0);
      check("cs_n",  a_cs_n, ph == PH_REC);
      check("ready_busy", a_ready, 0);
      check("done",  a_done, k == TAS + 1 + TDS + 1);
      check("bus_en", a_en, (ph == PH_ADDR) || (ph == PH_AHOLD) || (ph == PH_DATA && !rd));
      if (ph == PH_ADDR || ph == PH_AHOLD) check("bus_addr", a_bus_out, addr);
      if (ph == PH_DATA && !rd)            check("bus_wdata", a_bus_out, wdata);
      if (ph != PH_AHOLD) check("rw", a_rw, (ph == PH_REC) ? 1'b1 : rd);
      if (a_done) dones++;
      if (rd && k == TAS + 1 + TDS + 1) begin
        exp_rdata = rdv;
        check("rdata_at_done", a_rdata, rdv);
      end
    end
    step;
    check("ready_back", a_ready, 1);
    check("cs_n_idle", a_cs_n, 1);
    check("done_idle", a_done, 0);
    check("rdata_held", a_rdata, exp_rdata);
    check("done_count", dones, 1);
  endtask

  initial begin
    reset = 1'b1;
    a_req = 1'b1; a_rd = 1'b0; a_addr = 8'h11; a_wdata = 8'h22; a_bus_in = 8'h00;
    b_req = 1'b1; b_rd = 1'b0; b_addr = 8'h33; b_wdata = 8'h44; b_bus_in = 8'h00;
    exp_rdata = 8'h00;
    repeat (3) step;
    // Reset state, with req asserted alongside reset
    check("rst_ready", a_ready, 1);
    check("rst_done", a_done, 0);
    check("rst_rdata", a_rdata, 8'h00);
    check("rst_as", a_as, 0);
    check("rst_ds", a_ds, 0);
    check("rst_rw", a_rw, 1);
    check("rst_cs_n", a_cs_n, 1);
    check("rst_bus", a_bus_out, 8'h00);
    check("rst_en", a_en, 0);
    reset = 1'b0; a_req = 1'b0; b_req = 1'b0;
    step;

    // Read aborted by reset in the 2nd DATA cycle
    a_req = 1'b1; a_rd = 1'b1; a_addr = 8'h28;
    step;
    a_req = 1'b0;
    repeat (TAS + 1 + 1) step;
    check("abort_in_data", a_ds, 1);
    reset = 1'b1; a_bus_in = 8'hEE;
    step;
    reset = 1'b0;
    check("abort_cs_n", a_cs_n, 1);
    check("abort_ds", a_ds, 0);
    check("abort_ready", a_ready, 1);
    check("abort_done", a_done, 0);
    check("abort_rdata", a_rdata, exp_rdata);
    step;
    check("abort_no_done", a_done, 0);

    // Directed write and read with default timing
    run_access(1'b0, 8'h21, 8'h5A, 8'h00, 1'b0, 1'b0);
    run_access(1'b1, 8'h28, 8'h00, 8'hC3, 1'b0, 1'b0);
    // Request pulsed during DATA is ignored
    run_access(1'b0, 8'h30, 8'hA5, 8'h00, 1'b0, 1'b1);
    // req held across two back-to-back accesses
    run_access(1'b1, 8'h2A, 8'h00, 8'h3C, 1'b1, 1'b0);
    run_access(1'b0, 8'h2B, 8'h96, 8'h00, 1'b0, 1'b0);

    // Randomized accesses
    for (int n = 0; n < 24; n++) begin
      bit hold, poke;
      hold = (n < 23) ? 1'($urandom) : 1'b0;
      poke = hold ? 1'b0 : 1'($urandom);
      run_access(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), hold, poke);
    end
    a_req = 1'b0;

    // Minimum timing instance: 4-cycle access, write then read
    for (int r = 0; r < 2; r++) begin
      logic [7:0] ad, wd, rv;
      ad = 8'($urandom); wd = 8'($urandom); rv = 8'($urandom);
      check("b_ready_start", b_ready, 1);
      b_req = 1'b1; b_rd = (r == 1); b_addr = ad; b_wdata = wd;
      for (int k = 1; k <= 4; k++) begin
        int ph;
        step;
        b_req = 1'b0; b_addr = 8'($urandom); b_wdata = 8'($urandom);
        ph = phase_of(k, 1, 1);
        b_bus_in = (ph == PH_DATA) ? rv : 8'($urandom);
        check("b_as", b_as, ph == PH_ADDR);
        check("b_ds", b_ds, ph == PH_DATA);
        check("b_as_ds_excl", b_as & b_ds, 0);
        check("b_cs_n", b_cs_n, ph == PH_REC);
        check("b_done", b_done, k == 4);
        check("b_ready_busy", b_ready, 0);
        if (ph == PH_ADDR || ph == PH_AHOLD) check("b_bus_addr", b_bus_out, ad);
        if (ph == PH_DATA) check("b_bus_en_data", b_en, r == 0);
        if (ph == PH_DATA && r == 0) check("b_bus_wdata", b_bus_out, wd);
        if (r == 1 && k == 4) check("b_rdata", b_rdata, rv);
      end
      step;
      check("b_ready_back", b_ready, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
